uart_rx_frame_ctrl: RTL and testbench

Frame controller placed directly after the UART receiver. It consumes the receiver's byte strobe and byte value and parses frames of the form SOF, LEN, payload[LEN], CHK. Payload bytes are written into an internal FIFO that supports commit and rollback, so downstream logic only ever sees payloads from frames whose checksum passed. Downstream reads through a valid/ready interface, and the block reports per-frame status pulses.

---
 rtl/uart_rx_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser behind the UART receiver: SOF, LEN, payload[LEN], CHK into a commit/rollback FIFO.
// Optional inter-byte timeout is compiled in with `define RX_TIMEOUT_EN.
//
// state     | meaning
// S_IDLE    | hunting for SOF_BYTE, other bytes dropped
// S_LEN     | next byte is the payload length
// S_PAYLOAD | payload bytes written speculatively past commit_ptr
// S_CHK     | next byte is the XOR checksum (LEN ^ payload)
module uart_rx_frame_ctrl #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    MAX_LEN       = 16,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE      = 'hA5,
  parameter int                    FIFO_DEPTH    = 16,
  parameter int                    TIMEOUT_TICKS = 640
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  s_tick,
  input  logic                  rx_done_tick,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic [DATA_WIDTH-1:0] payload_data,
  output logic                  payload_valid,
  input  logic                  payload_ready,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic                  busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK} state_t;

  state_t                  state_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q, commit_ptr_q;
  logic [DATA_WIDTH-1:0]   chk_acc_q, len_q, byte_cnt_q;
  logic                    frame_done_q, frame_err_q;
  logic [1:0]              err_code_q;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic                    full, pop, wr_en, timeout;

  // Full uses the pre-pop rd_ptr, so a same-cycle pop cannot rescue an overflow.
  assign full          = (wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH);
  assign payload_valid = (rd_ptr_q != commit_ptr_q);
  assign pop           = payload_valid && payload_ready;
  assign wr_en         = rx_done_tick && (state_q == S_PAYLOAD) && !full;
  assign payload_data  = payload_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;
  assign err_code      = err_code_q;
  assign busy          = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= rx_data;
  end

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] to_cnt_q;

  // Down-counter reloaded by every byte and while idle; a byte in the expiry cycle wins.
  assign timeout = (state_q != S_IDLE) && !rx_done_tick && (to_cnt_q == '0);

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      to_cnt_q <= TW'(TIMEOUT_TICKS);
    end else if (rx_done_tick || state_q == S_IDLE || timeout) begin
      to_cnt_q <= TW'(TIMEOUT_TICKS);
    end else if (s_tick && to_cnt_q != '0) begin
      to_cnt_q <= to_cnt_q - 1'b1;
    end
  end
`else
  localparam int unused_timeout_ticks = TIMEOUT_TICKS;
  logic unused_s_tick;
  assign unused_s_tick = s_tick;
  assign timeout       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_ptr_q <= '0;
      chk_acc_q    <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (rx_done_tick) begin
        case (state_q)
          S_IDLE: begin
            if (rx_data == SOF_BYTE) state_q <= S_LEN;
          end
          S_LEN: begin
            if (rx_data == '0 || rx_data > MAX_LEN_W) begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'd1;
              state_q     <= S_IDLE;
            end else begin
              len_q      <= rx_data;
              byte_cnt_q <= '0;
              chk_acc_q  <= rx_data;
              state_q    <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (full) begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'd3;
              wr_ptr_q    <= commit_ptr_q;
              state_q     <= S_IDLE;
            end else begin
              wr_ptr_q   <= wr_ptr_q + 1'b1;
              chk_acc_q  <= chk_acc_q ^ rx_data;
              byte_cnt_q <= byte_cnt_q + 1'b1;
              if (byte_cnt_q == len_q - 1'b1) state_q <= S_CHK;
            end
          end
          S_CHK: begin
            if (rx_data == chk_acc_q) begin
              commit_ptr_q <= wr_ptr_q;
              frame_done_q <= 1'b1;
            end else begin
              wr_ptr_q    <= commit_ptr_q;
              frame_err_q <= 1'b1;
              err_code_q  <= 2'd2;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (timeout) begin
        frame_err_q <= 1'b1;
        err_code_q  <= 2'd0;
        wr_ptr_q    <= commit_ptr_q;
        state_q     <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed and randomized frame checks for uart_rx_frame_ctrl; expected payloads and
// outcomes come from the frames the bench builds itself.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       payload_ready = 1'b0;
  logic [7:0] payload_data;
  logic       payload_valid, frame_done, frame_err, busy;
  logic [1:0] err_code;

  uart_rx_frame_ctrl dut (
    .clk(clk), .reset_in(reset_in), .s_tick(s_tick),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_ready(payload_ready), .frame_done(frame_done),
    .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_done = 0, n_err = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pl[$];

  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic send_q(input bit gaps);
    while (tx_q.size() > 0) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(tx_q.pop_front());
    end
  endtask

  task automatic drain(input string tag);
    payload_ready = 1'b1;
    while (exp_q.size() > 0) begin
      chk({tag, "_valid"}, 32'(payload_valid), 1);
      chk({tag, "_data"}, 32'(payload_data), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
    payload_ready = 1'b0;
    chk({tag, "_empty"}, 32'(payload_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int d0, e0, kind, len, seen;
  logic [7:0] b, ck;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(payload_data), 0);
    chk("rst_valid", 32'(payload_valid), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_in = 1'b1;
    @(negedge clk);

    // good frame A5 03 11 22 33 03
    send_byte(8'hA5);
    chk("f1_busy", 32'(busy), 1);
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("f1_pre_valid", 32'(payload_valid), 0);
    chk("f1_pre_done", 32'(frame_done), 0);
    send_byte(8'h03);
    chk("f1_done", 32'(frame_done), 1);
    chk("f1_valid", 32'(payload_valid), 1);
    chk("f1_err", 32'(frame_err), 0);
    chk("f1_busy_end", 32'(busy), 0);
    @(negedge clk);
    chk("f1_done_pulse", 32'(frame_done), 0);
    exp_q = '{8'h11, 8'h22, 8'h33};
    drain("f1");

    // bad checksum
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_q(1'b0);
    send_byte(8'h04);
    chk("f2_err", 32'(frame_err), 1);
    chk("f2_code", 32'(err_code), 2);
    chk("f2_done", 32'(frame_done), 0);
    chk("f2_valid", 32'(payload_valid), 0);

    // leading garbage then single-byte frame; also shows the rollback left no stale bytes
    d0 = n_done;
    tx_q = '{8'h55, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_q(1'b0);
    chk("f4_done", 32'(frame_done), 1);
    repeat (2) @(negedge clk);
    chk("f4_done_cnt", 32'(n_done - d0), 1);
    exp_q = '{8'h7E};
    drain("f4");

    // bad LEN: zero and MAX_LEN+1
    send_byte(8'hA5); send_byte(8'h00);
    chk("f3a_err", 32'(frame_err), 1);
    chk("f3a_code", 32'(err_code), 1);
    send_byte(8'hA5); send_byte(8'h11);
    chk("f3b_err", 32'(frame_err), 1);
    chk("f3b_code", 32'(err_code), 1);
    chk("f3_valid", 32'(payload_valid), 0);
    chk("f3_busy", 32'(busy), 0);

    // overflow: 16 committed bytes, next frame dies on its first payload byte
    tx_q = '{8'hA5, 8'h10};
    ck = 8'h10;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
      exp_q.push_back(b);
      ck ^= b;
    end
    tx_q.push_back(ck);
    send_q(1'b1);
    chk("ov_done", 32'(frame_done), 1);
    tx_q = '{8'hA5, 8'h02};
    send_q(1'b0);
    d0 = n_done;
    send_byte(8'h01);
    chk("ov_err", 32'(frame_err), 1);
    chk("ov_code", 32'(err_code), 3);
    send_byte(8'h02); send_byte(8'h03);
    repeat (2) @(negedge clk);
    chk("ov_busy", 32'(busy), 0);
    chk("ov_no_done", 32'(n_done - d0), 0);
    drain("ov");

    // inter-byte timeout boundary
    tx_q = '{8'hA5, 8'h02, 8'h01};
    send_q(1'b0);
    e0 = n_err;
    s_tick = 1'b1;
    repeat (639) @(negedge clk);
    s_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_early_err", 32'(n_err - e0), 0);
    chk("to_early_busy", 32'(busy), 1);
`ifdef RX_TIMEOUT_EN
    s_tick = 1'b1;
    @(negedge clk);
    s_tick = 1'b0;
    seen = 0;
    for (int i = 0; i < 6 && seen == 0; i++) begin
      @(negedge clk);
      if (frame_err) seen = 1;
    end
    chk("to_err_seen", 32'(seen), 1);
    chk("to_code", 32'(err_code), 0);
    chk("to_busy", 32'(busy), 0);
    chk("to_valid", 32'(payload_valid), 0);
    tx_q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    send_q(1'b0);
    chk("to_next_done", 32'(frame_done), 1);
    exp_q = '{8'h5A};
    drain("to_next");
`else
    s_tick = 1'b1;
    repeat (60) @(negedge clk);
    s_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("nto_err", 32'(n_err - e0), 0);
    chk("nto_busy", 32'(busy), 1);
    send_byte(8'h02); send_byte(8'h01);
    chk("nto_done", 32'(frame_done), 1);
    exp_q = '{8'h01, 8'h02};
    drain("nto");
`endif

    // reset mid-payload with a committed frame still queued
    tx_q = '{8'hA5, 8'h01, 8'h42, 8'h43};
    send_q(1'b0);
    chk("rm_commit", 32'(payload_valid), 1);
    tx_q = '{8'hA5, 8'h04, 8'h11, 8'h22};
    send_q(1'b0);
    repeat (2) @(negedge clk);
    d0 = n_done; e0 = n_err;
    reset_in = 1'b0;
    #1;
    chk("rm_valid", 32'(payload_valid), 0);
    chk("rm_data", 32'(payload_data), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_code", 32'(err_code), 0);
    @(negedge clk);
    reset_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rm_no_pulse", 32'((n_done - d0) + (n_err - e0)), 0);
    chk("rm_empty", 32'(payload_valid), 0);
    chk("rm_idle", 32'(busy), 0);

    // randomized frames: 0 good, 1 bad CHK, 2 bad LEN, 3 garbage + good
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 16));
      tx_q.delete();
      pl.delete();
      if (kind == 3) begin
        repeat ($urandom_range(1, 3)) begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h00;
          tx_q.push_back(b);
        end
      end
      tx_q.push_back(8'hA5);
      if (kind == 2) begin
        b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255));
        tx_q.push_back(b);
      end else begin
        ck = 8'(len);
        tx_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          pl.push_back(b);
          ck ^= b;
          tx_q.push_back(b);
        end
        if (kind == 1) ck ^= 8'($urandom_range(1, 255));
        tx_q.push_back(ck);
      end
      d0 = n_done; e0 = n_err;
      send_q(1'b1);
      repeat (2) @(negedge clk);
      chk("rnd_done", 32'(n_done - d0), (kind == 0 || kind == 3) ? 1 : 0);
      chk("rnd_err", 32'(n_err - e0), (kind == 1 || kind == 2) ? 1 : 0);
      chk("rnd_busy", 32'(busy), 0);
      if (kind == 1) chk("rnd_code_chk", 32'(err_code), 2);
      if (kind == 2) chk("rnd_code_len", 32'(err_code), 1);
      if (kind == 0 || kind == 3) exp_q = pl;
      drain("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
